// File: rtl/marc_control_unit.sv
// Hardwired control unit for the mARC 16-bit datapath: fetch / PC increment / decode / execute sequencing
// plus the memory handshake. Define CU_WAIT_TIMEOUT_EN to add the memory wait-state timeout and FAULT state.
module marc_control_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        z,
    input  logic        mem_ready,
    output logic [3:0]  addrA,
    output logic [3:0]  addrB,
    output logic [3:0]  addrD,
    output logic        rw,
    output logic [3:0]  alu_op,
    output logic [1:0]  dsel,
    output logic [15:0] imm,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        illegal,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH, S_PC_INC, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_HALT, S_FAULT
    } state_t;

    localparam logic [3:0] R_DISP   = 4'h8;
    localparam logic [3:0] R_CONST2 = 4'hC;
    localparam logic [3:0] R_TEMP0  = 4'hD;
    localparam logic [3:0] R_PC     = 4'hE;
    localparam logic [3:0] R_IR     = 4'hF;

    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BZ   = 4'h7;
    localparam logic [3:0] OP_SETD = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] ALU_ADD = 4'h0;

    localparam logic [1:0] DSEL_ALU = 2'd0;
    localparam logic [1:0] DSEL_MEM = 2'd1;
    localparam logic [1:0] DSEL_IMM = 2'd2;

    state_t     state;
    logic [3:0] op, rd, rs1, rs2;

    assign op  = ir[15:12];
    assign rd  = {1'b0, ir[11:9]};
    assign rs1 = {1'b0, ir[8:6]};
    assign rs2 = {1'b0, ir[5:3]};
    assign imm = {{4{ir[11]}}, ir[11:0]};

`ifdef CU_WAIT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
`ifdef CU_WAIT_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        state <= (state == S_FETCH) ? S_PC_INC : S_FETCH;
`ifdef CU_WAIT_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= S_FAULT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_PC_INC: state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_LD || op == OP_ST) state <= S_ADDR;
                    else if (op == OP_HALT)         state <= S_HALT;
                    else                            state <= S_EXEC;
                end
                S_EXEC:  state <= S_FETCH;
                S_ADDR:  state <= S_MEM;
                S_HALT:  state <= S_HALT;
                default: state <= state;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        addrA   = 4'h0;
        addrB   = 4'h0;
        addrD   = 4'h0;
        rw      = 1'b0;
        alu_op  = ALU_ADD;
        dsel    = DSEL_ALU;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        fault   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    addrA  = R_PC;
                    addrD  = R_IR;
                    dsel   = DSEL_MEM;
                    mem_rd = 1'b1;
                    rw     = mem_ready;
                end
                S_PC_INC: begin
                    addrA = R_PC;
                    addrB = R_CONST2;
                    addrD = R_PC;
                    rw    = 1'b1;
                end
                S_EXEC: begin
                    if (op <= 4'h4) begin
                        addrA  = rs1;
                        addrB  = rs2;
                        alu_op = op;
                        addrD  = rd;
                        rw     = 1'b1;
                    end else if (op == OP_BZ) begin
                        addrA = R_PC;
                        addrB = R_DISP;
                        addrD = R_PC;
                        rw    = z;
                    end else if (op == OP_SETD) begin
                        addrD = R_DISP;
                        dsel  = DSEL_IMM;
                        rw    = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                S_ADDR: begin
                    addrA = rs1;
                    addrB = R_DISP;
                    addrD = R_TEMP0;
                    rw    = 1'b1;
                end
                S_MEM: begin
                    // Write-back of a load lands on the same edge that retires the request.
                    addrA = R_TEMP0;
                    if (op == OP_LD) begin
                        mem_rd = 1'b1;
                        addrD  = rd;
                        dsel   = DSEL_MEM;
                        rw     = mem_ready;
                    end else begin
                        mem_wr = 1'b1;
                        addrB  = rd;
                    end
                end
                S_HALT: halted = 1'b1;
`ifdef CU_WAIT_TIMEOUT_EN
                S_FAULT: fault = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_marc_control_unit.sv
// Self-checking bench for marc_control_unit: each instruction is expanded into its expected
// cycle-by-cycle output trace from the ISA rules, then driven with random don't-care mem_ready.
module tb_marc_control_unit;

    logic        clk = 1'b0;
    logic        reset, z, mem_ready;
    logic [15:0] ir;
    logic [3:0]  addrA, addrB, addrD, alu_op;
    logic [1:0]  dsel;
    logic [15:0] imm;
    logic        rw, mem_rd, mem_wr, halted, illegal, fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    marc_control_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .ir(ir), .z(z), .mem_ready(mem_ready),
        .addrA(addrA), .addrB(addrB), .addrD(addrD), .rw(rw), .alu_op(alu_op),
        .dsel(dsel), .imm(imm), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .halted(halted), .illegal(illegal), .fault(fault)
    );

    typedef struct packed {
        logic [3:0] a, b, d;
        logic       rw;
        logic [3:0] alu;
        logic [1:0] dsel;
        logic       mrd, mwr, hlt, ill, flt;
    } obs_t;

    typedef struct packed {
        obs_t exp;
        logic rdy;
        logic care;
    } step_t;

    obs_t  act;
    step_t plan[$];

    assign act = {addrA, addrB, addrD, rw, alu_op, dsel, mem_rd, mem_wr, halted, illegal, fault};

    function automatic logic [15:0] sext12(input logic [15:0] i);
        int v;
        v = int'(i[11:0]);
        if (v >= 2048) v = v - 4096;
        return 16'(v);
    endfunction

    function automatic obs_t fetch_obs(input logic ready);
        obs_t e;
        e = '0; e.a = 4'hE; e.d = 4'hF; e.dsel = 2'd1; e.mrd = 1'b1; e.rw = ready;
        return e;
    endfunction

    task automatic push(input obs_t e, input logic rdy, input logic care);
        step_t s;
        s.exp = e; s.rdy = rdy; s.care = care;
        plan.push_back(s);
    endtask

    // Expected trace of one instruction from its opcode class, fetch waits fw and memory waits mw.
    task automatic build(input logic [15:0] i, input logic zz, input int fw, input int mw);
        obs_t e;
        logic [3:0] op, rd, rs1, rs2;
        op = i[15:12]; rd = {1'b0, i[11:9]}; rs1 = {1'b0, i[8:6]}; rs2 = {1'b0, i[5:3]};
        plan.delete();
        repeat (fw) push(fetch_obs(1'b0), 1'b0, 1'b1);
        push(fetch_obs(1'b1), 1'b1, 1'b1);
        e = '0; e.a = 4'hE; e.b = 4'hC; e.d = 4'hE; e.rw = 1'b1;
        push(e, 1'b0, 1'b0);
        push('0, 1'b0, 1'b0);
        if (op == 4'h5 || op == 4'h6) begin
            e = '0; e.a = rs1; e.b = 4'h8; e.d = 4'hD; e.rw = 1'b1;
            push(e, 1'b0, 1'b0);
            e = '0; e.a = 4'hD;
            if (op == 4'h5) begin e.mrd = 1'b1; e.d = rd; e.dsel = 2'd1; end
            else            begin e.mwr = 1'b1; e.b = rd; end
            repeat (mw) push(e, 1'b0, 1'b1);
            if (op == 4'h5) e.rw = 1'b1;
            push(e, 1'b1, 1'b1);
        end else if (op == 4'hF) begin
            e = '0; e.hlt = 1'b1;
            push(e, 1'b0, 1'b0);
        end else begin
            e = '0;
            if (op <= 4'h4) begin
                e.a = rs1; e.b = rs2; e.alu = op; e.d = rd; e.rw = 1'b1;
            end else if (op == 4'h7) begin
                e.a = 4'hE; e.b = 4'h8; e.d = 4'hE; e.rw = zz;
            end else if (op == 4'h8) begin
                e.d = 4'h8; e.dsel = 2'd2; e.rw = 1'b1;
            end else begin
                e.ill = 1'b1;
            end
            push(e, 1'b0, 1'b0);
        end
    endtask

    // Starts and ends at posedge+1. abort_at >= 0 asserts reset mid-cycle at that step.
    task automatic run(input string name, input logic [15:0] i, input logic zz,
                       input int fw, input int mw, input int abort_at);
        build(i, zz, fw, mw);
        ir = i; z = zz;
        foreach (plan[k]) begin
            mem_ready = plan[k].care ? plan[k].rdy : 1'($urandom);
            @(negedge clk);
            checks++;
            if (act !== plan[k].exp) begin
                failures++;
                $display("FAIL %s step=%0d got=%h exp=%h", name, k, act, plan[k].exp);
            end
            if (k == 0) begin
                checks++;
                if (imm !== sext12(i)) begin
                    failures++;
                    $display("FAIL %s_imm got=%h exp=%h", name, imm, sext12(i));
                end
            end
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1 checks++;
                if (act !== obs_t'('0)) begin
                    failures++;
                    $display("FAIL %s_reset_drop got=%h exp=%h", name, act, obs_t'('0));
                end
                @(posedge clk); #1 reset = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; ir = 16'h0298; z = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (act !== obs_t'('0)) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=%h", act, obs_t'('0));
            end
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_directed;
        run("add_r1_r2_r3", 16'h0298, 1'b0, 0, 0, -1);
        run("ld_wait3", 16'h5280, 1'b0, 0, 3, -1);
        run("bz_taken", 16'h7000, 1'b1, 0, 0, -1);
        run("bz_not_taken", 16'h7000, 1'b0, 1, 0, -1);
        run("illegal_a", 16'hA000, 1'b0, 0, 0, -1);
        run("setd_neg", 16'h8FFE, 1'b0, 2, 0, -1);
        run("st_wait2", 16'h6E40, 1'b0, 0, 2, -1);
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [15:0] i;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 14));
            i  = {op, 12'($urandom)};
            run("random", i, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 6; n++)
            run("back_to_back", {4'($urandom_range(0, 8)), 12'($urandom)}, 1'($urandom), 0, 0, -1);
    endtask

    task automatic test_reset_mid_mem;
        // Steps 0..3 are fetch/pc_inc/decode/addr; step 4 is the first MEM wait cycle.
        run("st_reset_mid", 16'h6280, 1'b0, 0, 5, 4);
        run("after_mid_reset", 16'h0298, 1'b0, 0, 0, -1);
    endtask

    task automatic test_halt;
        obs_t e;
        run("halt_entry", 16'hF000, 1'b0, 0, 0, -1);
        e = '0; e.hlt = 1'b1;
        for (int c = 0; c < 19; c++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL halt_hold cyc=%0d got=%h exp=%h", c, act, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== obs_t'('0)) begin
            failures++;
            $display("FAIL halt_reset got=%h exp=%h", act, obs_t'('0));
        end
        @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (act !== fetch_obs(1'b0)) begin
            failures++;
            $display("FAIL halt_restart got=%h exp=%h", act, fetch_obs(1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        obs_t e;
        mem_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
`ifdef CU_WAIT_TIMEOUT_EN
            if (c < 15) e = fetch_obs(1'b0);
            else begin e = '0; e.flt = 1'b1; end
`else
            e = fetch_obs(1'b0);
`endif
            @(negedge clk);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL fetch_wait cyc=%0d got=%h exp=%h", c, act, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        run("after_timeout", 16'h1498, 1'b0, 0, 0, -1);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; ir = 16'h0; z = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_mem;
        test_halt;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/marc_control_unit.md
# marc_control_unit

Microprogram-free hardwired control unit for the mARC 16-bit datapath. It is the initiator side of the file-register port: each cycle it drives the A/B read addresses, the D write address, the write strobe and the ALU/data-source selects, sequencing fetch, PC increment, decode and execute. It also owns the memory read/write handshake. It sits between the instruction register output of the file register and the datapath muxes.

## Interface
- `TIMEOUT`, default 15: memory wait-state limit in cycles (used only with `CU_WAIT_TIMEOUT_EN`).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ir`  in  16  instruction register value from the file register (address 0xF).
- `z`  in  1  zero flag of the last ALU result (PSR).
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `addrA`, `addrB`, `addrD`  out  4  file-register read A / read B / write addresses.
- `rw`  out  1  file-register write enable.
- `alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A.
- `dsel`  out  2  write-data source: 0 ALU, 1 memory, 2 `imm`.
- `imm`  out  16  sign-extended `ir[11:0]`, combinational.
- `mem_rd`, `mem_wr`  out  1  memory request; address is file-register busA, write data is busB.
- `halted`, `illegal`, `fault`  out  1  status.

## Operation
- Instruction fields: `op=ir[15:12]`, `rd=ir[11:9]`, `rs1=ir[8:6]`, `rs2=ir[5:3]`. Register map: 0–7 general (0 reads zero), 8 displacement, 9 maskl, A pimm4, B nimm4, C const2, D temp0, E pc, F ir.
- States: FETCH, PC_INC, DECODE, EXEC, ADDR, MEM, HALT, FAULT.
- FETCH: addrA=E, mem_rd=1, addrD=F, dsel=1, rw=mem_ready. mem_ready=1 → PC_INC, else stay.
- PC_INC: addrA=E, addrB=C, alu_op=ADD, addrD=E, rw=1 → DECODE (pc += 2).
- DECODE: no writes, rw=0. op 0x0–0x4, 0x7, 0x8, 0x9–0xE → EXEC; op 0x5/0x6 → ADDR; op 0xF → HALT.
- EXEC: op 0–4: addrA=rs1, addrB=rs2, alu_op=op, addrD=rd, rw=1. op 7 (BZ): addrA=E, addrB=8, ADD, addrD=E, rw=z. op 8 (SETD): addrD=8, dsel=2, rw=1. op 9–E: rw=0, `illegal` pulses 1 cycle. → FETCH.
- ADDR (LD/ST): addrA=rs1, addrB=8, ADD, addrD=D, rw=1 (temp0 = rs1 + displacement) → MEM.
- MEM: addrA=D held. LD: mem_rd=1, addrD=rd, dsel=1, rw=mem_ready. ST: mem_wr=1, addrB=rd, rw=0. mem_ready → FETCH, else stay.
- HALT: all strobes 0, `halted`=1, exits only on reset.
- Unused outputs in each state are 0. mem_rd and mem_wr never both 1.

## Timing
- Reset: state ← FETCH. Any cycle with reset=1 forces all outputs 0 (addrA/B/D=0, rw=0, alu_op=0, dsel=0, mem_rd/mem_wr=0, halted/illegal/fault=0) and clears the wait counter. Reset mid-handshake drops mem_rd/mem_wr immediately.
- State is registered; outputs are decoded from state and `ir`. rw in FETCH and MEM(LD) is combinational on mem_ready (Mealy), so the write lands at the same edge that retires the request.
- Request strobes and addresses are stable from assertion until the cycle mem_ready is sampled high.
- Zero-wait latency: ALU/BZ/SETD/illegal 4 cycles; LD/ST 5 cycles; each wait state adds 1 cycle.
- mem_ready outside FETCH/MEM is ignored.

## Configuration
- `CU_WAIT_TIMEOUT_EN` defined: a 4-bit+ wait counter increments each FETCH/MEM cycle with mem_ready=0, clears on state exit. When the count reaches `TIMEOUT` without mem_ready, the unit enters FAULT: strobes 0, `fault`=1 until reset.
- Undefined: no counter, waits forever; `fault` tied 0, FAULT unreachable.

## Test plan
- Reset, then ir=0x0298 (ADD r1,r2,r3), mem_ready always 1 → FETCH/PC_INC/DECODE/EXEC in 4 cycles; EXEC shows addrA=2, addrB=3, addrD=1, alu_op=0, rw=1; PC_INC shows addrA=E, addrB=C, addrD=E.
- LD ir=0x5280 (rd=1, rs1=2), mem_ready low 3 cycles in MEM → ADDR writes addrD=D; mem_rd held 4 cycles with addrA=D; rw=1 only in the mem_ready cycle with addrD=1, dsel=1.
- BZ ir=0x7000 with z=1 → EXEC rw=1, addrD=E; repeat with z=0 → rw=0, next state FETCH.
- ir=0xF000 → halted=1 after DECODE, no strobes for 20 cycles; reset → halted=0, mem_rd=1 in the first post-reset cycle.
- ir=0xA000 → illegal=1 for exactly 1 cycle, rw=0, back to FETCH; reset asserted during MEM wait → mem_wr=0 same cycle.
- With `CU_WAIT_TIMEOUT_EN`, TIMEOUT=15, mem_ready held 0 in FETCH → fault=1 after 15 wait cycles, mem_rd=0; without macro mem_rd stays 1 for 100 cycles.
